aq_ifu_icache_data_ctrl: RTL and testbench

Arbiter and sequencer for the IFU instruction-cache data array. It shares the single-ported data SRAMs between three requesters: line refill writes, IOP (cache-op debug) reads and instruction-fetch reads. It drives the array's index, read-enable, write-enable, write-data and IOP control inputs, and returns captured IOP read data. It sits between the IFU fetch pipe / linefill buffer / CP0 cache-op logic and the data array.

---
 rtl/aq_ifu_icache_data_ctrl_pkg.sv | 20 ++
 rtl/aq_ifu_icache_data_ctrl.sv | 155 +++++++++++++++
 tb/tb_aq_ifu_icache_data_ctrl.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aq_ifu_icache_data_ctrl_pkg.sv
// Shared IFU definitions for the icache data-array controller:
// FSM state encoding, default index width and refill beat count.
package aq_ifu_icache_data_ctrl_pkg;

    localparam int I_DATA_INDEX_WIDTH = 14;
    localparam int REFILL_BEATS       = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REFILL  = 2'd1,
        ST_IOP_RD  = 2'd2,
        ST_IOP_RSP = 2'd3
    } dctrl_state_e;

    // One-hot write enable for a 2-way array.
    function automatic logic [1:0] way_onehot(input logic way);
        return way ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/aq_ifu_icache_data_ctrl.sv
// Arbiter/sequencer for the single-ported IFU icache data array.
// Ports: refill (req/gnt, beat vld/rdy, done), IOP read (req/gnt,
// rdata/vld), fetch (req/gnt), and the array idx/ren/wen/din/IOP strobes.
module aq_ifu_icache_data_ctrl
    import aq_ifu_icache_data_ctrl_pkg::*;
#(
    parameter int IDX_W = I_DATA_INDEX_WIDTH,
    parameter int BEATS = REFILL_BEATS
) (
    input  logic             forever_cpuclk,
    input  logic             cpurst,
    input  logic             ifetch_req,
    input  logic [IDX_W-1:0] ifetch_idx,
    input  logic [1:0]       ifetch_ren,
    output logic             ifetch_gnt,
    input  logic             refill_req,
    input  logic [IDX_W-1:0] refill_idx,
    input  logic             refill_way,
    output logic             refill_gnt,
    input  logic             refill_data_vld,
    input  logic [127:0]     refill_data,
    output logic             refill_data_rdy,
    output logic             refill_done,
    input  logic             iop_req,
    input  logic [IDX_W-1:0] iop_idx,
    input  logic             iop_way,
    output logic             iop_gnt,
    output logic             iop_rdata_vld,
    output logic [127:0]     iop_rdata,
    input  logic [31:0]      icache_data0_dout,
    input  logic [31:0]      icache_data1_dout,
    input  logic [31:0]      icache_data2_dout,
    input  logic [31:0]      icache_data3_dout,
    output logic [IDX_W-1:0] icache_data_idx,
    output logic [1:0]       icache_data_ren,
    output logic [1:0]       icache_data_wen,
    output logic [127:0]     icache_data_din,
    output logic             iop_rd_data,
    output logic             iop_rd_way
);

    localparam int CW = $clog2(BEATS);

    dctrl_state_e     state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             way_q, way_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             vld_q, vld_d;
    logic [127:0]     rdata_q, rdata_d;

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            way_q   <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            vld_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            way_q   <= way_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            vld_q   <= vld_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        way_d           = way_q;
        cnt_d           = cnt_q;
        done_d          = 1'b0;
        vld_d           = 1'b0;
        rdata_d         = rdata_q;
        ifetch_gnt      = 1'b0;
        refill_gnt      = 1'b0;
        refill_data_rdy = 1'b0;
        iop_gnt         = 1'b0;
        icache_data_idx = '0;
        icache_data_ren = 2'b00;
        icache_data_wen = 2'b00;
        icache_data_din = '0;
        iop_rd_data     = 1'b0;
        iop_rd_way      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (refill_req) begin
                    refill_gnt = 1'b1;
                    idx_d      = refill_idx;
                    way_d      = refill_way;
                    cnt_d      = '0;
                    state_d    = ST_REFILL;
                end else if (iop_req) begin
                    iop_gnt = 1'b1;
                    idx_d   = iop_idx;
                    way_d   = iop_way;
                    state_d = ST_IOP_RD;
                end else if (ifetch_req) begin
                    ifetch_gnt      = 1'b1;
                    icache_data_idx = ifetch_idx;
                    icache_data_ren = ifetch_ren;
                end
            end
            ST_REFILL: begin
                refill_data_rdy = 1'b1;
                if (refill_data_vld) begin
                    icache_data_wen = way_onehot(way_q);
                    icache_data_din = refill_data;
                    // Each beat covers four 32-bit words of the line.
                    icache_data_idx = {idx_q[IDX_W-1:2+CW], cnt_q, 2'b00};
                    cnt_d           = cnt_q + 1'b1;
                    if (cnt_q == CW'(BEATS - 1)) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_IOP_RD: begin
                iop_rd_data     = 1'b1;
                iop_rd_way      = way_q;
                icache_data_idx = idx_q;
                state_d         = ST_IOP_RSP;
            end
            ST_IOP_RSP: begin
                // Array output from the IOP read is valid this cycle.
                rdata_d = {icache_data3_dout, icache_data2_dout,
                           icache_data1_dout, icache_data0_dout};
                vld_d   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (cpurst) begin
            ifetch_gnt      = 1'b0;
            refill_gnt      = 1'b0;
            refill_data_rdy = 1'b0;
            iop_gnt         = 1'b0;
            icache_data_ren = 2'b00;
            icache_data_wen = 2'b00;
            iop_rd_data     = 1'b0;
        end
    end

    assign refill_done   = done_q;
    assign iop_rdata_vld = vld_q;
    assign iop_rdata     = rdata_q;

endmodule

// File: tb/tb_aq_ifu_icache_data_ctrl.sv
// Directed testbench for aq_ifu_icache_data_ctrl.
// Inputs change 1ns after posedge, outputs are checked 4ns after posedge.
module tb_aq_ifu_icache_data_ctrl;

    logic         clk = 1'b0;
    logic         cpurst;
    logic         ifetch_req;
    logic [13:0]  ifetch_idx;
    logic [1:0]   ifetch_ren;
    logic         ifetch_gnt;
    logic         refill_req;
    logic [13:0]  refill_idx;
    logic         refill_way;
    logic         refill_gnt;
    logic         refill_data_vld;
    logic [127:0] refill_data;
    logic         refill_data_rdy;
    logic         refill_done;
    logic         iop_req;
    logic [13:0]  iop_idx;
    logic         iop_way;
    logic         iop_gnt;
    logic         iop_rdata_vld;
    logic [127:0] iop_rdata;
    logic [31:0]  d0, d1, d2, d3;
    logic [13:0]  a_idx;
    logic [1:0]   a_ren;
    logic [1:0]   a_wen;
    logic [127:0] a_din;
    logic         iop_rd_data;
    logic         iop_rd_way;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    aq_ifu_icache_data_ctrl dut (
        .forever_cpuclk    (clk),
        .cpurst            (cpurst),
        .ifetch_req        (ifetch_req),
        .ifetch_idx        (ifetch_idx),
        .ifetch_ren        (ifetch_ren),
        .ifetch_gnt        (ifetch_gnt),
        .refill_req        (refill_req),
        .refill_idx        (refill_idx),
        .refill_way        (refill_way),
        .refill_gnt        (refill_gnt),
        .refill_data_vld   (refill_data_vld),
        .refill_data       (refill_data),
        .refill_data_rdy   (refill_data_rdy),
        .refill_done       (refill_done),
        .iop_req           (iop_req),
        .iop_idx           (iop_idx),
        .iop_way           (iop_way),
        .iop_gnt           (iop_gnt),
        .iop_rdata_vld     (iop_rdata_vld),
        .iop_rdata         (iop_rdata),
        .icache_data0_dout (d0),
        .icache_data1_dout (d1),
        .icache_data2_dout (d2),
        .icache_data3_dout (d3),
        .icache_data_idx   (a_idx),
        .icache_data_ren   (a_ren),
        .icache_data_wen   (a_wen),
        .icache_data_din   (a_din),
        .iop_rd_data       (iop_rd_data),
        .iop_rd_way        (iop_rd_way)
    );

    function automatic logic [127:0] beat(input int i);
        logic [31:0] w;
        w = 32'hC0DE_0000 + 32'(i);
        return {w, ~w, w ^ 32'h5A5A_5A5A, 32'(i * 3)};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        refill_req      = 1'b0;
        refill_data_vld = 1'b0;
        iop_req         = 1'b0;
        ifetch_req      = 1'b0;
        ifetch_ren      = 2'b00;
    endtask

    task automatic test_reset();
        cpurst          = 1'b1;
        refill_req      = 1'b1;
        refill_idx      = 14'h0440;
        refill_way      = 1'b1;
        refill_data_vld = 1'b1;
        refill_data     = '0;
        iop_req         = 1'b1;
        iop_idx         = 14'h0200;
        iop_way         = 1'b0;
        ifetch_req      = 1'b1;
        ifetch_idx      = 14'h0123;
        ifetch_ren      = 2'b11;
        d0 = '0; d1 = '0; d2 = '0; d3 = '0;
        cyc();
        cyc();
        #3;
        checks++;
        if ({ifetch_gnt, refill_gnt, iop_gnt, refill_data_rdy} !== 4'b0) begin
            failures++;
            $display("FAIL rst_gnt got=%b exp=0000",
                     {ifetch_gnt, refill_gnt, iop_gnt, refill_data_rdy});
        end
        checks++;
        if ({a_ren, a_wen, iop_rd_data} !== 5'b0) begin
            failures++;
            $display("FAIL rst_arr got=%b exp=00000", {a_ren, a_wen, iop_rd_data});
        end
        checks++;
        if ({refill_done, iop_rdata_vld} !== 2'b00 || iop_rdata !== 128'h0) begin
            failures++;
            $display("FAIL rst_regs done=%b vld=%b rdata=%h exp 0/0/0",
                     refill_done, iop_rdata_vld, iop_rdata);
        end
        cyc();
        cpurst = 1'b0;
        clr_in();
    endtask

    task automatic test_fetch();
        cyc();
        #3;
        checks++;
        if (ifetch_gnt !== 1'b0 || a_ren !== 2'b00) begin
            failures++;
            $display("FAIL idle_noreq gnt=%b ren=%b exp 0/00", ifetch_gnt, a_ren);
        end
        cyc();
        ifetch_req = 1'b1;
        ifetch_idx = 14'h0123;
        ifetch_ren = 2'b01;
        #3;
        checks++;
        if (ifetch_gnt !== 1'b1 || a_idx !== 14'h0123 ||
            a_ren !== 2'b01 || a_wen !== 2'b00) begin
            failures++;
            $display("FAIL fetch gnt=%b idx=%h ren=%b wen=%b exp 1/0123/01/00",
                     ifetch_gnt, a_idx, a_ren, a_wen);
        end
        cyc();
        clr_in();
    endtask

    task automatic test_refill();
        logic [13:0] e;
        cyc();
        refill_req = 1'b1;
        refill_idx = 14'h0440;
        refill_way = 1'b1;
        ifetch_req = 1'b1;
        ifetch_idx = 14'h0123;
        ifetch_ren = 2'b01;
        #3;
        checks++;
        if (refill_gnt !== 1'b1 || ifetch_gnt !== 1'b0 || a_wen !== 2'b00) begin
            failures++;
            $display("FAIL rf_gnt rgnt=%b fgnt=%b wen=%b exp 1/0/00",
                     refill_gnt, ifetch_gnt, a_wen);
        end
        for (int i = 0; i < 4; i++) begin
            cyc();
            refill_req      = 1'b0;
            refill_data_vld = 1'b1;
            refill_data     = beat(i);
            e = 14'h0440 + 14'(4 * i);
            #3;
            checks++;
            if (a_wen !== 2'b10 || a_idx !== e || a_din !== beat(i) ||
                refill_data_rdy !== 1'b1 || ifetch_gnt !== 1'b0 ||
                a_ren !== 2'b00) begin
                failures++;
                $display("FAIL rf_beat%0d wen=%b idx=%h din=%h rdy=%b fgnt=%b exp 10/%h/%h/1/0",
                         i, a_wen, a_idx, a_din, refill_data_rdy, ifetch_gnt, e, beat(i));
            end
        end
        cyc();
        refill_data_vld = 1'b0;
        #3;
        checks++;
        if (refill_done !== 1'b1 || ifetch_gnt !== 1'b1 || a_wen !== 2'b00) begin
            failures++;
            $display("FAIL rf_done done=%b fgnt=%b wen=%b exp 1/1/00",
                     refill_done, ifetch_gnt, a_wen);
        end
        cyc();
        clr_in();
        #3;
        checks++;
        if (refill_done !== 1'b0) begin
            failures++;
            $display("FAIL rf_done_pulse done=%b exp 0", refill_done);
        end
    endtask

    task automatic test_gap();
        int pat[6] = '{1, 1, 0, 0, 1, 1};
        int b = 0;
        int writes = 0;
        logic [13:0] e;
        logic [1:0] ew;
        cyc();
        refill_req = 1'b1;
        refill_idx = 14'h0440;
        refill_way = 1'b0;
        ifetch_req = 1'b1;
        ifetch_ren = 2'b10;
        #3;
        checks++;
        if (refill_gnt !== 1'b1) begin
            failures++;
            $display("FAIL gap_gnt got=%b exp=1", refill_gnt);
        end
        for (int i = 0; i < 6; i++) begin
            cyc();
            refill_req      = 1'b0;
            refill_data_vld = (pat[i] != 0);
            refill_data     = beat(b + 8);
            e  = 14'h0440 + 14'(4 * b);
            ew = (pat[i] != 0) ? 2'b01 : 2'b00;
            #3;
            if (a_wen !== 2'b00) writes++;
            checks++;
            if (a_wen !== ew || a_ren !== 2'b00 || ifetch_gnt !== 1'b0 ||
                refill_done !== 1'b0 ||
                (pat[i] != 0 && (a_idx !== e || a_din !== beat(b + 8)))) begin
                failures++;
                $display("FAIL gap_cyc%0d wen=%b ren=%b fgnt=%b done=%b idx=%h exp %b/00/0/0/%h",
                         i, a_wen, a_ren, ifetch_gnt, refill_done, a_idx, ew, e);
            end
            b += pat[i];
        end
        cyc();
        refill_data_vld = 1'b0;
        #3;
        checks++;
        if (refill_done !== 1'b1 || writes !== 4) begin
            failures++;
            $display("FAIL gap_done done=%b writes=%0d exp 1/4", refill_done, writes);
        end
        cyc();
        clr_in();
    endtask

    task automatic test_iop();
        logic [127:0] exp_d;
        exp_d = 128'h0000000D_0000000C_0000000B_0000000A;
        d0 = 32'hA; d1 = 32'hB; d2 = 32'hC; d3 = 32'hD;
        cyc();
        iop_req    = 1'b1;
        iop_idx    = 14'h0200;
        iop_way    = 1'b0;
        ifetch_req = 1'b1;
        ifetch_ren = 2'b01;
        #3;
        checks++;
        if (iop_gnt !== 1'b1 || ifetch_gnt !== 1'b0) begin
            failures++;
            $display("FAIL iop_gnt igt=%b fgnt=%b exp 1/0", iop_gnt, ifetch_gnt);
        end
        cyc();
        iop_req = 1'b0;
        #3;
        checks++;
        if (iop_rd_data !== 1'b1 || iop_rd_way !== 1'b0 || a_idx !== 14'h0200 ||
            a_ren !== 2'b00 || ifetch_gnt !== 1'b0) begin
            failures++;
            $display("FAIL iop_rd rd=%b way=%b idx=%h ren=%b fgnt=%b exp 1/0/0200/00/0",
                     iop_rd_data, iop_rd_way, a_idx, a_ren, ifetch_gnt);
        end
        cyc();
        #3;
        checks++;
        if (ifetch_gnt !== 1'b0 || iop_rd_data !== 1'b0 || iop_rdata_vld !== 1'b0) begin
            failures++;
            $display("FAIL iop_rsp fgnt=%b rd=%b vld=%b exp 0/0/0",
                     ifetch_gnt, iop_rd_data, iop_rdata_vld);
        end
        cyc();
        d0 = 32'h1; d1 = 32'h2; d2 = 32'h3; d3 = 32'h4;
        #3;
        checks++;
        if (iop_rdata_vld !== 1'b1 || iop_rdata !== exp_d || ifetch_gnt !== 1'b1) begin
            failures++;
            $display("FAIL iop_data vld=%b rdata=%h fgnt=%b exp 1/%h/1",
                     iop_rdata_vld, iop_rdata, ifetch_gnt, exp_d);
        end
        cyc();
        clr_in();
        #3;
        checks++;
        if (iop_rdata_vld !== 1'b0 || iop_rdata !== exp_d) begin
            failures++;
            $display("FAIL iop_hold vld=%b rdata=%h exp 0/%h", iop_rdata_vld, iop_rdata, exp_d);
        end
    endtask

    task automatic test_back_to_back();
        // expected {refill_gnt, iop_gnt, ifetch_gnt} per cycle
        logic [2:0] eg[9] = '{3'b100, 3'b000, 3'b000, 3'b000, 3'b000,
                              3'b010, 3'b000, 3'b000, 3'b001};
        int ops;
        for (int c = 0; c < 9; c++) begin
            cyc();
            refill_req      = (c == 0);
            refill_idx      = 14'h0100;
            refill_way      = 1'b0;
            refill_data_vld = (c >= 1 && c <= 4);
            refill_data     = beat(c + 20);
            iop_req         = (c <= 5);
            iop_idx         = 14'h0300;
            iop_way         = 1'b1;
            ifetch_req      = 1'b1;
            ifetch_ren      = 2'b11;
            #3;
            ops = int'(a_ren != 2'b00) + int'(a_wen != 2'b00) + int'(iop_rd_data);
            checks++;
            if ({refill_gnt, iop_gnt, ifetch_gnt} !== eg[c] || ops > 1) begin
                failures++;
                $display("FAIL b2b_cyc%0d gnts=%b ops=%0d exp %b/<=1",
                         c, {refill_gnt, iop_gnt, ifetch_gnt}, ops, eg[c]);
            end
            if (c == 6) begin
                checks++;
                if (iop_rd_data !== 1'b1 || iop_rd_way !== 1'b1 || a_idx !== 14'h0300) begin
                    failures++;
                    $display("FAIL b2b_iop rd=%b way=%b idx=%h exp 1/1/0300",
                             iop_rd_data, iop_rd_way, a_idx);
                end
            end
        end
        cyc();
        clr_in();
    endtask

    task automatic test_reset_mid_refill();
        cyc();
        refill_req = 1'b1;
        refill_idx = 14'h0880;
        refill_way = 1'b1;
        #3;
        checks++;
        if (refill_gnt !== 1'b1) begin
            failures++;
            $display("FAIL rmid_gnt got=%b exp=1", refill_gnt);
        end
        for (int i = 0; i < 2; i++) begin
            cyc();
            refill_req      = 1'b0;
            refill_data_vld = 1'b1;
            refill_data     = beat(i + 40);
            #3;
            checks++;
            if (a_wen !== 2'b10) begin
                failures++;
                $display("FAIL rmid_beat%0d wen=%b exp 10", i, a_wen);
            end
        end
        cyc();
        cpurst      = 1'b1;
        refill_data = beat(42);
        #3;
        checks++;
        if (a_wen !== 2'b00 || refill_data_rdy !== 1'b0) begin
            failures++;
            $display("FAIL rmid_rst wen=%b rdy=%b exp 00/0", a_wen, refill_data_rdy);
        end
        cyc();
        cyc();
        cpurst     = 1'b0;
        ifetch_req = 1'b1;
        ifetch_idx = 14'h0123;
        ifetch_ren = 2'b10;
        #3;
        checks++;
        if (ifetch_gnt !== 1'b1 || a_ren !== 2'b10 || a_wen !== 2'b00 ||
            refill_done !== 1'b0 || refill_data_rdy !== 1'b0) begin
            failures++;
            $display("FAIL rmid_rel fgnt=%b ren=%b wen=%b done=%b rdy=%b exp 1/10/00/0/0",
                     ifetch_gnt, a_ren, a_wen, refill_done, refill_data_rdy);
        end
        cyc();
        clr_in();
        #3;
        checks++;
        if (refill_done !== 1'b0) begin
            failures++;
            $display("FAIL rmid_nodone done=%b exp 0", refill_done);
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_refill();
        test_gap();
        test_iop();
        test_back_to_back();
        test_reset_mid_refill();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
